// File: rtl/buffer_escritura_registros.sv
// rtl/buffer_escritura_registros.sv - register file write-back FIFO with pending-write lookup
// Optional same-cycle bypass into an empty, unstalled buffer: define WB_BYPASS_EN.
module buffer_escritura_registros #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     rf_stall,
  output logic                     rf_write_enable,
  output logic [ADDR_W-1:0]        rf_write_reg,
  output logic [DATA_W-1:0]        rf_write_data,
  input  logic [ADDR_W-1:0]        query_reg_1,
  input  logic [ADDR_W-1:0]        query_reg_2,
  output logic                     query_hit_1,
  output logic                     query_hit_2,
  output logic [DATA_W-1:0]        query_data_1,
  output logic [DATA_W-1:0]        query_data_2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_reg  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push;
  logic              pop;
  logic              bypass;
  logic [PTR_W-1:0]  idx;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !full;

`ifdef WB_BYPASS_EN
  assign bypass = empty && !rf_stall && in_valid && (in_reg != '0);
`else
  assign bypass = 1'b0;
`endif

  // Register 0 writes are acknowledged but dropped; bypassed requests never enter storage.
  assign push = in_valid && in_ready && (in_reg != '0) && !bypass;
  assign pop  = !empty && !rf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[tail]  <= in_reg;
      mem_data[tail] <= in_data;
    end
  end

  always_comb begin
    rf_write_enable = pop || bypass;
    rf_write_reg    = '0;
    rf_write_data   = '0;
    if (bypass) begin
      rf_write_reg  = in_reg;
      rf_write_data = in_data;
    end else if (!empty) begin
      rf_write_reg  = mem_reg[head];
      rf_write_data = mem_data[head];
    end
  end

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    query_hit_1  = 1'b0;
    query_hit_2  = 1'b0;
    query_data_1 = '0;
    query_data_2 = '0;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if ((query_reg_1 != '0) && (mem_reg[idx] == query_reg_1)) begin
          query_hit_1  = 1'b1;
          query_data_1 = mem_data[idx];
        end
        if ((query_reg_2 != '0) && (mem_reg[idx] == query_reg_2)) begin
          query_hit_2  = 1'b1;
          query_data_2 = mem_data[idx];
        end
      end
    end
  end

endmodule
